// File: rtl/pc_pkg.sv
// pc_pkg: shared FSM state encodings and default vectors for the PC generator.
package pc_pkg;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;
  localparam logic [31:0] PC_RESET_VEC = 32'h0040_0000;
  localparam logic [31:0] PC_EXC_VEC   = 32'h0040_0004;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/pc_redirect_sel.sv
// pc_redirect_sel: priority select of the next fetch target plus misalign check.
// Ports: exc_valid_i/redir_valid_i/redir_pc_i new redirect requests, pend_v_i/pend_pc_i
// buffered redirect; target_o winning address, take_o any redirect wins, misalign_o
// redirect replaced by EXC_VEC.
module pc_redirect_sel
  import pc_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(PC_EXC_VEC)
) (
  input  logic             exc_valid_i,
  input  logic             redir_valid_i,
  input  logic [WIDTH-1:0] redir_pc_i,
  input  logic             pend_v_i,
  input  logic [WIDTH-1:0] pend_pc_i,
  output logic [WIDTH-1:0] target_o,
  output logic             take_o,
  output logic             misalign_o
);
  // An exception masks the misalign report since its vector wins anyway.
  assign misalign_o = redir_valid_i & ~exc_valid_i & (|redir_pc_i[1:0]);
  assign take_o     = exc_valid_i | redir_valid_i | pend_v_i;
  assign target_o   = (exc_valid_i | misalign_o) ? EXC_VEC :
                      redir_valid_i ? redir_pc_i : pend_pc_i;
endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with fetch handshake, redirect buffer, exceptions and halt.
// Ports: clk/reset (async, active-high), en global enable, stall/halt control,
// redir_valid/redir_pc/exc_valid redirect sources, fetch_req/fetch_addr/fetch_ack memory
// handshake, pc_o/pc_valid committed PC to decode, misalign redirect-replaced pulse.
module pc_gen
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC),
  parameter int               STEP      = PC_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             stall,
  input  logic             halt,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_pc,
  input  logic             exc_valid,
  output logic             fetch_req,
  output logic [WIDTH-1:0] fetch_addr,
  input  logic             fetch_ack,
  output logic [WIDTH-1:0] pc_o,
  output logic             pc_valid,
  output logic             misalign
);
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] fa_q, fa_d, pc_q, pc_d, pend_pc_q, pend_pc_d, target;
  logic             pend_v_q, pend_v_d, valid_q, valid_d, mis_q, mis_d;
  logic             take, mis_sel, ack, fresh;

  pc_redirect_sel #(.WIDTH(WIDTH), .EXC_VEC(EXC_VEC)) u_sel (
    .exc_valid_i  (exc_valid),
    .redir_valid_i(redir_valid),
    .redir_pc_i   (redir_pc),
    .pend_v_i     (pend_v_q),
    .pend_pc_i    (pend_pc_q),
    .target_o     (target),
    .take_o       (take),
    .misalign_o   (mis_sel)
  );

  assign fetch_req  = (state_q == REQ) & en & ~stall;
  assign ack        = fetch_req & fetch_ack;
  assign fresh      = exc_valid | redir_valid;
  assign fetch_addr = fa_q;
  assign pc_o       = pc_q;
  assign pc_valid   = valid_q & en;
  assign misalign   = mis_q;

  // A redirect seen while stalled is parked in pend_pc and applied on the
  // first unstalled edge; an ack on that edge returns a stale word and is dropped.
  always_comb begin
    state_d   = halt ? HALTED : (state_q == IDLE) ? REQ : state_q;
    fa_d      = fa_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    pend_v_d  = pend_v_q;
    valid_d   = 1'b0;
    mis_d     = mis_sel & (state_q != HALTED);
    if (state_q != HALTED) begin
      if (ack && !take) begin
        pc_d    = fa_q;
        valid_d = 1'b1;
        fa_d    = fa_q + WIDTH'(STEP);
      end else if (ack || (!stall && take)) begin
        fa_d     = target;
        pend_v_d = 1'b0;
      end else if (stall && fresh) begin
        pend_pc_d = target;
        pend_v_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      fa_q      <= RESET_VEC;
      pc_q      <= RESET_VEC;
      pend_pc_q <= RESET_VEC;
      pend_v_q  <= 1'b0;
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
    end else if (en) begin
      state_q   <= state_d;
      fa_q      <= fa_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      pend_v_q  <= pend_v_d;
      valid_q   <= valid_d;
      mis_q     <= mis_d;
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard-based self-checking bench for pc_gen.
module tb_pc_gen;
  localparam logic [31:0] RV = 32'h0040_0000;
  localparam logic [31:0] EV = 32'h0040_0004;

  logic        clk = 1'b0, reset = 1'b1, en = 1'b1, stall = 1'b0, halt = 1'b0;
  logic        redir_valid = 1'b0, exc_valid = 1'b0, fetch_ack = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        fetch_req, pc_valid, misalign;
  logic [31:0] fetch_addr, pc_o;

  int checks = 0, fails = 0;
  logic [31:0] sb[$];

  pc_gen dut (
    .clk(clk), .reset(reset), .en(en), .stall(stall), .halt(halt),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .exc_valid(exc_valid),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .pc_o(pc_o), .pc_valid(pc_valid), .misalign(misalign)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && pc_valid) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pc_valid: pc_o=%h, no pc_valid was expected", pc_o);
      end else begin
        logic [31:0] exp_pc;
        exp_pc = sb.pop_front();
        if (pc_o !== exp_pc) begin
          fails++;
          $display("FAIL scoreboard_pc: got %h expected %h", pc_o, exp_pc);
        end
      end
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    redir_valid = 1'b0; exc_valid = 1'b0; fetch_ack = 1'b0; stall = 1'b0; halt = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    go(); go();
    @(negedge clk);
    checks++;
    if ({fetch_req, pc_valid, misalign, pc_o, fetch_addr} !== {3'b000, RV, RV}) begin
      fails++;
      $display("FAIL reset_values: req/val/mis=%b%b%b pc=%h fa=%h", fetch_req, pc_valid, misalign, pc_o, fetch_addr);
    end
    go();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_req !== 1'b0) begin
      fails++;
      $display("FAIL idle_cycle_req: got %b expected 0", fetch_req);
    end
    go();
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      fetch_ack = 1'b1;
      @(negedge clk);
      checks++;
      if (fetch_req !== 1'b1 || fetch_addr !== RV + 32'(4 * i)) begin
        fails++;
        $display("FAIL seq_fetch_%0d: req=%b fa=%h expected req=1 fa=%h", i, fetch_req, fetch_addr, RV + 32'(4 * i));
      end
      if (i > 0) begin
        checks++;
        if (pc_valid !== 1'b1) begin
          fails++;
          $display("FAIL seq_back_to_back_%0d: pc_valid=%b expected 1", i, pc_valid);
        end
      end
      sb.push_back(RV + 32'(4 * i));
      go();
    end
    fetch_ack = 1'b0;
    go(); go();
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL seq_drain: %0d pc_valid pulses missing, expected 0", sb.size());
    end
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1;
    redir_valid = 1'b1; redir_pc = 32'h0040_0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (fetch_req !== 1'b0 || fetch_addr !== 32'h0040_000C) begin
        fails++;
        $display("FAIL stall_%0d: req=%b fa=%h expected req=0 fa=0040000c", i, fetch_req, fetch_addr);
      end
      go();
      redir_valid = 1'b0;
    end
    stall = 1'b0;
    fetch_ack = 1'b1;
    go();
    fetch_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (pc_valid !== 1'b0 || fetch_addr !== 32'h0040_0100) begin
      fails++;
      $display("FAIL stall_release: pc_valid=%b fa=%h expected 0 and 00400100", pc_valid, fetch_addr);
    end
    fetch_ack = 1'b1;
    sb.push_back(32'h0040_0100);
    go();
    fetch_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_addr !== 32'h0040_0104) begin
      fails++;
      $display("FAIL stall_after: fa=%h expected 00400104", fetch_addr);
    end
    go();
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL stall_drain: %0d pc_valid pulses missing, expected 0", sb.size());
    end
  endtask

  task automatic test_ack_redirect();
    fetch_ack = 1'b1; redir_valid = 1'b1; redir_pc = 32'h0040_0040;
    go();
    clear_in();
    @(negedge clk);
    checks++;
    if (pc_valid !== 1'b0 || fetch_addr !== 32'h0040_0040) begin
      fails++;
      $display("FAIL ack_redirect: pc_valid=%b fa=%h expected 0 and 00400040", pc_valid, fetch_addr);
    end
  endtask

  task automatic test_misalign();
    redir_valid = 1'b1; redir_pc = 32'h0040_0042;
    go();
    clear_in();
    @(negedge clk);
    checks++;
    if (misalign !== 1'b1 || fetch_addr !== EV) begin
      fails++;
      $display("FAIL misalign: mis=%b fa=%h expected 1 and %h", misalign, fetch_addr, EV);
    end
    redir_valid = 1'b1; redir_pc = 32'h0040_0080;
    go();
    clear_in();
    @(negedge clk);
    checks++;
    if (misalign !== 1'b0 || fetch_addr !== 32'h0040_0080) begin
      fails++;
      $display("FAIL aligned_redirect: mis=%b fa=%h expected 0 and 00400080", misalign, fetch_addr);
    end
    redir_valid = 1'b1; redir_pc = 32'h0040_0042; exc_valid = 1'b1;
    go();
    clear_in();
    @(negedge clk);
    checks++;
    if (misalign !== 1'b0 || fetch_addr !== EV) begin
      fails++;
      $display("FAIL exc_with_misalign: mis=%b fa=%h expected 0 and %h", misalign, fetch_addr, EV);
    end
  endtask

  task automatic test_wrap();
    redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFC;
    go();
    clear_in();
    fetch_ack = 1'b1;
    sb.push_back(32'hFFFF_FFFC);
    go();
    fetch_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_addr !== 32'h0000_0000) begin
      fails++;
      $display("FAIL wrap: fa=%h expected 00000000", fetch_addr);
    end
    go();
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL wrap_drain: %0d pc_valid pulses missing, expected 0", sb.size());
    end
  endtask

  task automatic test_enable();
    en = 1'b0; fetch_ack = 1'b1; redir_valid = 1'b1; redir_pc = 32'h0040_0300;
    @(negedge clk);
    checks++;
    if (fetch_req !== 1'b0 || pc_valid !== 1'b0) begin
      fails++;
      $display("FAIL enable_low: req=%b pc_valid=%b expected 0 and 0", fetch_req, pc_valid);
    end
    go();
    en = 1'b1;
    clear_in();
    @(negedge clk);
    checks++;
    if (fetch_addr !== 32'h0 || pc_o !== 32'hFFFF_FFFC) begin
      fails++;
      $display("FAIL enable_freeze: fa=%h pc=%h expected 00000000 and fffffffc", fetch_addr, pc_o);
    end
  endtask

  task automatic test_halt();
    fetch_ack = 1'b1;
    sb.push_back(32'h0);
    go();
    fetch_ack = 1'b0; halt = 1'b1;
    go();
    halt = 1'b0; fetch_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (fetch_req !== 1'b0 || pc_o !== 32'h0 || pc_valid !== 1'b0) begin
        fails++;
        $display("FAIL halted_%0d: req=%b pc=%h val=%b expected 0, 00000000, 0", i, fetch_req, pc_o, pc_valid);
      end
      go();
    end
    fetch_ack = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL halt_drain: %0d pc_valid pulses missing, expected 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    go();
    reset = 1'b0;
    go();
    stall = 1'b1; redir_valid = 1'b1; redir_pc = 32'h0040_0200;
    go();
    clear_in();
    fetch_ack = 1'b1;
    #1;
    checks++;
    if (fetch_req !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_pre: req=%b expected 1", fetch_req);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({fetch_req, pc_valid, misalign, pc_o, fetch_addr} !== {3'b000, RV, RV}) begin
      fails++;
      $display("FAIL reset_mid: req/val/mis=%b%b%b pc=%h fa=%h", fetch_req, pc_valid, misalign, pc_o, fetch_addr);
    end
    go();
    reset = 1'b0; fetch_ack = 1'b0;
    go(); go();
    @(negedge clk);
    checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== RV || pc_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_pend_cleared: req=%b fa=%h val=%b expected 1, %h, 0", fetch_req, fetch_addr, pc_valid, RV);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_redirect();
    test_ack_redirect();
    test_misalign();
    test_wrap();
    test_enable();
    test_halt();
    test_reset_mid();
    go();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
